// File: rtl/debounce_scheduler.sv
// debounce_scheduler: one shared countdown timer debounces four buttons in round-robin order
module debounce_scheduler #(
  parameter int COUNT = 4095
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] raw,
  output logic [3:0] clean,
  output logic       busy,
  output logic [1:0] grant
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;
  logic [0:0] state_q, state_d;
  logic [11:0] counter_q, counter_d;
  logic [3:0] raw_q, pending_q, pending_d, clean_q, clean_d, found_re, own;
  logic [1:0] ptr_q, ptr_d, grant_q, grant_d, p1, p2, p3, sel;
  logic counting, idle_go, done;
  always_comb begin
    found_re = raw & ~raw_q;
    counting = state_q == S_COUNT;
    idle_go = !counting && |pending_q;
    done = counting && counter_q == 12'd1;
    p1 = ptr_q + 2'd1;
    p2 = ptr_q + 2'd2;
    p3 = ptr_q + 2'd3;
    sel = pending_q[ptr_q] ? ptr_q : pending_q[p1] ? p1 : pending_q[p2] ? p2 : p3;
    own = counting ? 4'b1 << grant_q : 4'b0;
    pending_d = (pending_q | (found_re & ~own)) & ~(idle_go ? 4'b1 << sel : 4'b0);
    state_d = idle_go ? S_COUNT : done ? S_IDLE : state_q;
    counter_d = idle_go ? 12'(COUNT) : counting ? counter_q - 12'd1 : counter_q;
    grant_d = idle_go ? sel : grant_q;
    ptr_d = done ? grant_q + 2'd1 : ptr_q;
    clean_d = done ? {3'b0, raw[grant_q]} << grant_q : 4'b0;
  end
  always_ff @(posedge clock) begin
    raw_q <= raw;
    if (!reset) begin
      state_q <= S_IDLE;
      counter_q <= 12'd0;
      pending_q <= 4'b0;
      ptr_q <= 2'd0;
      grant_q <= 2'd0;
      clean_q <= 4'b0;
    end else begin
      state_q <= state_d;
      counter_q <= counter_d;
      pending_q <= pending_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      clean_q <= clean_d;
    end
  end
  assign clean = clean_q;
  assign busy = state_q == S_COUNT;
  assign grant = grant_q;
endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: directed self-checking bench for debounce_scheduler with COUNT=8
module tb_debounce_scheduler;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [3:0] raw = 4'b0;
  logic [3:0] clean;
  logic busy;
  logic [1:0] grant;
  int errors = 0;
  int checks = 0;
  debounce_scheduler #(.COUNT(8)) dut (
    .clock(clock),
    .reset(reset),
    .raw(raw),
    .clean(clean),
    .busy(busy),
    .grant(grant)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b0;
    raw = 4'b0;
    step();
    step();
    reset = 1'b1;
  endtask
  initial begin
    do_reset();
    chk("reset_clean", 32'(clean), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_grant", 32'(grant), 0);
    raw = 4'b0001;
    step();
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e == 1) chk("single_grant", 32'(grant), 0);
      chk($sformatf("single_busy_E%0d", e), 32'(busy), (e <= 8) ? 1 : 0);
      chk($sformatf("single_clean_E%0d", e), 32'(clean), (e == 9) ? 1 : 0);
    end
    do_reset();
    raw = 4'b0010;
    step();
    raw = 4'b0000;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 1) chk("bounce_grant", 32'(grant), 1);
      chk($sformatf("bounce_busy_E%0d", e), 32'(busy), (e <= 8) ? 1 : 0);
      chk($sformatf("bounce_clean_E%0d", e), 32'(clean), (e == 9) ? 2 : 0);
      if (e == 1 || e == 3) raw = 4'b0010;
      if (e == 2) raw = 4'b0000;
    end
    do_reset();
    raw = 4'b0101;
    step();
    for (int e = 1; e <= 19; e++) begin
      step();
      if (e == 1) chk("simul_grant0", 32'(grant), 0);
      if (e == 10) chk("simul_grant2", 32'(grant), 2);
      chk($sformatf("simul_busy_E%0d", e), 32'(busy), ((e <= 8) || (e >= 10 && e <= 17)) ? 1 : 0);
      chk($sformatf("simul_clean_E%0d", e), 32'(clean), (e == 9) ? 1 : (e == 18) ? 4 : 0);
    end
    do_reset();
    raw = 4'b0001;
    step();
    repeat (9) step();
    chk("rr_first_clean", 32'(clean), 1);
    raw = 4'b0000;
    step();
    raw = 4'b1001;
    step();
    step();
    chk("rr_grant3", 32'(grant), 3);
    chk("rr_busy3", 32'(busy), 1);
    repeat (8) step();
    chk("rr_clean3", 32'(clean), 8);
    step();
    chk("rr_wrap_grant0", 32'(grant), 0);
    chk("rr_wrap_busy", 32'(busy), 1);
    repeat (8) step();
    chk("rr_clean0", 32'(clean), 1);
    do_reset();
    raw = 4'b0100;
    step();
    for (int e = 1; e <= 10; e++) begin
      step();
      if (e == 1) chk("release_grant", 32'(grant), 2);
      chk($sformatf("release_busy_E%0d", e), 32'(busy), (e <= 8) ? 1 : 0);
      chk($sformatf("release_clean_E%0d", e), 32'(clean), 0);
      if (e == 4) raw = 4'b0000;
    end
    raw = 4'b1100;
    step();
    step();
    chk("release_ptr3_grant", 32'(grant), 3);
    do_reset();
    raw = 4'b0001;
    step();
    repeat (4) step();
    chk("midrst_busy_before", 32'(busy), 1);
    reset = 1'b0;
    step();
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_clean", 32'(clean), 0);
    chk("midrst_grant", 32'(grant), 0);
    reset = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      chk($sformatf("midrst_idle_busy_%0d", e), 32'(busy), 0);
      chk($sformatf("midrst_idle_clean_%0d", e), 32'(clean), 0);
    end
    raw = 4'b0000;
    step();
    raw = 4'b0001;
    step();
    step();
    chk("midrst_repress_busy", 32'(busy), 1);
    chk("midrst_repress_grant", 32'(grant), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
